// File: rtl/mul_cell_arbiter_pkg.sv
// Shared types and helpers for the multiply-cell arbiter: FSM state encoding,
// cell operand width and the pass-B skip test.
package mul_cell_arbiter_pkg;

  localparam int MUL_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Pass B contributes (hi2*lo1)<<16, which vanishes when either factor is zero
  function automatic logic skip_b(input logic [MUL_W-1:0] op1,
                                  input logic [MUL_W-1:0] op2);
    return (op2[31:16] == 16'h0) || (op1[15:0] == 16'h0);
  endfunction

endpackage

// File: rtl/mul_cell_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from last+1 (mod N_REQ) and returns
// the first requester as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Shares one pipelined low-word multiply cell among N_REQ requesters: round-robin
// grant, pass A / optional pass B sequencing, accumulate, valid/ready response.
module mul_cell_arbiter
  import mul_cell_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int CELL_LAT  = 1,
  parameter int SKIP_B_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [32*N_REQ-1:0]    req_src1,
  input  logic [32*N_REQ-1:0]    req_src2,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [MUL_W-1:0]       rsp_result,
  output logic [MUL_W-1:0]       mul_src1,
  output logic [MUL_W-1:0]       mul_src2,
  input  logic [MUL_W-1:0]       mul_cell_result,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAT_W = (CELL_LAT > 0) ? $clog2(CELL_LAT + 1) : 1;

  state_e             state, state_nxt;
  logic [IDX_W-1:0]   last, g_idx;
  logic [N_REQ-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [MUL_W-1:0]   op1, op2, sel_src1, sel_src2, acc;
  logic [LAT_W-1:0]   lat_cnt;
  logic               rsp_valid_q;
  logic               req_any, lat_done, skip;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_any  = |req_valid;
  assign lat_done = (lat_cnt == LAT_W'(CELL_LAT));
  assign skip     = (SKIP_B_EN != 0) && skip_b(op1, op2);

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_src1 = req_src1[32*i +: 32];
        sel_src2 = req_src2[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    mul_src1  = '0;
    mul_src2  = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (req_any) state_nxt = PASS_A;
      end
      PASS_A: begin
        mul_src1 = op1;
        mul_src2 = op2;
        if (lat_done) state_nxt = skip ? RESP : PASS_B;
      end
      PASS_B: begin
        // swapped pass: cell returns {(hi2*lo1)[15:0], 16'h0}
        mul_src1 = {op2[31:16], 16'h0};
        mul_src2 = {16'h0, op1[15:0]};
        if (lat_done) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready[g_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last        <= IDX_W'(N_REQ - 1);
      g_idx       <= '0;
      acc         <= '0;
      lat_cnt     <= '0;
      rsp_result  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_any) begin
            last    <= grant_idx;
            g_idx   <= grant_idx;
            lat_cnt <= '0;
          end
        end
        PASS_A: begin
          lat_cnt <= lat_done ? '0 : lat_cnt + LAT_W'(1);
          if (lat_done) begin
            acc <= mul_cell_result;
            if (skip) rsp_result <= mul_cell_result;
          end
        end
        PASS_B: begin
          lat_cnt <= lat_done ? '0 : lat_cnt + LAT_W'(1);
          if (lat_done) rsp_result <= acc + mul_cell_result;
        end
        RESP: begin
          if (!rsp_valid_q)             rsp_valid_q <= 1'b1;
          else if (rsp_ready[g_idx])    rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // operands are only meaningful while a request is in flight
  always_ff @(posedge clk) begin
    if (state == IDLE && req_any) begin
      op1 <= sel_src1;
      op2 <= sel_src2;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = rsp_valid_q && (g_idx == IDX_W'(i));
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mul_cell_arbiter.md
Name: mul_cell_arbiter

Overview:
- Shares one pipelined 32x32 low-word multiply cell among N requesters.
- The cell computes, per issue, {lo1*lo2[31:16] + (hi1*lo2)[15:0], lo1*lo2[15:0]}, where lo/hi are the 16-bit halves of src1/src2. The full low-32 product therefore needs a second swapped pass.
- This block round-robin arbitrates requests, sequences pass A and pass B, accumulates, and returns the result with a per-requester valid/ready handshake.
- Sits between custom-instruction/accelerator clients and the shared multiply cell in the car-control subsystem.

Parameters:
- N_REQ, 3: number of requesters, 1..8.
- CELL_LAT, 1: cycles from cell operand presentation to a valid mul_cell_result.
- SKIP_B_EN, 1: when 1, pass B is skipped if op2[31:16]==0 or op1[15:0]==0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot accept; combinational, only in IDLE
- req_src1  in  32*N_REQ  operand 1, requester i at [32i+31:32i]
- req_src2  in  32*N_REQ  operand 2, same packing
- rsp_valid  out  N_REQ  one-hot result valid to the granted requester
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_result  out  32  low 32 bits of op1*op2
- mul_src1  out  32  cell operand 1
- mul_src2  out  32  cell operand 2
- mul_cell_result  in  32  cell result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, busy, acc and lat_cnt all go to 0.
  - RR pointer last = N_REQ-1, so requester 0 wins first.
- States: IDLE, PASS_A, PASS_B, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], scanning from last+1 modulo N_REQ.
  - req_ready[g]=1 in the same cycle. The handshake completes on that edge.
  - On that edge: latch op1, op2 and g; set last=g, lat_cnt=0; go to PASS_A.
  - No req_valid: stay in IDLE, req_ready=0.
- PASS_A:
  - mul_src1=op1, mul_src2=op2, held stable for the whole pass.
  - lat_cnt increments each cycle.
  - When lat_cnt==CELL_LAT: acc=mul_cell_result, lat_cnt=0.
  - Next state: RESP if SKIP_B_EN and skip condition (rsp_result=acc), else PASS_B.
- PASS_B:
  - mul_src1={op2[31:16],16'h0}, mul_src2={16'h0,op1[15:0]}.
  - Cell then yields {(hi2*lo1)[15:0],16'h0}.
  - When lat_cnt==CELL_LAT: rsp_result = acc + mul_cell_result, modulo 2^32, carry discarded; go to RESP.
- RESP:
  - rsp_valid[g]=1; rsp_result held stable.
  - On rsp_ready[g]=1: rsp_valid cleared on that edge, go to IDLE. The next grant is evaluated in the following cycle.
  - rsp_ready of non-granted requesters is ignored.
- Latency from accept edge to rsp_valid:
  - With pass B: 2*(CELL_LAT+1)+1 cycles, i.e. 5 cycles for CELL_LAT=1.
  - Pass B skipped: CELL_LAT+2 cycles, i.e. 3 cycles.
- Operands are zero-extended; signedness is irrelevant for the low 32 bits.
- mul_src1 and mul_src2 are 0 outside PASS_A and PASS_B, which keeps the cell quiet.
- A requester dropping req_valid while not granted has no effect. Requests are never pre-empted.
- Reset mid-operation: the in-flight request is lost, no response is issued, and outputs return to reset values asynchronously.
- N_REQ=1: the arbiter degenerates to grant 0 whenever req_valid[0]=1.

Decomposition:
- Shared package: state enum (IDLE, PASS_A, PASS_B, RESP) and constant MUL_W=32.
- One sub-module, rr_arbiter:
  - Inputs: req vector and last pointer.
  - Outputs: one-hot grant and encoded index.
  - Combinational, N_REQ-parameterised; reusable by other shared-resource controllers.
- The FSM, operand muxing and accumulator stay in the top module.

Test Plan:
- Single request 0x00010003 x 0x00020005 from requester 0 -> both passes; rsp_result=0x000B000F; rsp_valid[0] rises 5 cycles after accept.
- 0xFFFFFFFF x 0x00000002 with SKIP_B_EN=1 -> pass B skipped; result 0xFFFFFFFE after 3 cycles. Same operands with SKIP_B_EN=0 -> same result after 5 cycles.
- 0xFFFFFFFF x 0xFFFFFFFF -> result 0x00000001; checks carry discard in both the cell and the accumulate.
- All 3 requesters hold req_valid continuously -> grant order 0,1,2,0,1; each rsp_valid is one-hot to the granted requester.
- Hold rsp_ready[g]=0 for 4 cycles in RESP; pulse rsp_ready of another requester -> rsp_valid and rsp_result stay stable, no new req_ready; release -> IDLE, next grant one cycle later.
- Assert reset_n=0 during PASS_B -> all outputs are 0 immediately; after release requester 0 has priority and no stale response appears.
